// File: rtl/arb_pkg.sv
// arb_pkg: shared types and sizing for the request arbiter.
//   state_t   - arbiter FSM state (IDLE=0, GRANT=1)
//   N_REQ_DEF - default number of request lines
//   id_w()    - grant index width for a given request count
package arb_pkg;
    localparam int N_REQ_DEF = 8;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: combinational priority encoder, highest set index wins.
//   vec - input bit vector (N wide)
//   idx - index of the highest set bit, 0 when none set
//   any - at least one bit of vec is set
module prio_enc
    import arb_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    parameter int W = id_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: captures requests into a pending register and serves them one
// at a time, highest index first, through a held grant with valid/ack.
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   req         - raw request lines, bit i is request i
//   ack         - consumer accepts the current grant
//   grant_valid - a grant is presented (registered)
//   grant_id    - index of the granted request, frozen while grant_valid=1
//   pending     - current pending register
// Build option: define REQ_EDGE_EN to pend only on rising edges of req
// (adds one cycle of request-to-grant latency).
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic [N_REQ-1:0] pending
);
    state_t           state;
    logic [N_REQ-1:0] set;
    logic [N_REQ-1:0] clr;
    logic [ID_W-1:0]  enc_idx;
    logic             enc_any;

`ifdef REQ_EDGE_EN
    // req is registered once before edge detection so the rise is judged on
    // two registered samples; this is the extra cycle of latency.
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] req_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            req_d <= '0;
        end else begin
            req_q <= req;
            req_d <= req_q;
        end
    end
    assign set = req_q & ~req_d;
`else
    assign set = req;
`endif

    assign clr = (state == GRANT && ack) ? (N_REQ'(1) << grant_id) : '0;

    prio_enc #(.N(N_REQ), .W(ID_W)) u_enc (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Set is OR'ed in after the clear so a same-cycle re-request survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            pending     <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
            if (state == IDLE) begin
                if (enc_any) begin
                    grant_id    <= enc_idx;
                    grant_valid <= 1'b1;
                    state       <= GRANT;
                end
            end else if (ack) begin
                grant_valid <= 1'b0;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed self-checking bench for req_arbiter (level mode).
module tb_req_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       ack = 1'b0;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [7:0] pending;
    int         checks = 0;
    int         failures = 0;

    req_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int hi;
        bit done;
        // reset defaults
        #12;
        check("rst_valid", {31'd0, grant_valid}, 0);
        check("rst_id", {29'd0, grant_id}, 0);
        check("rst_pend", {24'd0, pending}, 0);
        step();
        rst = 1'b0;
        // reach GRANT with pending=A0, then reset mid-cycle
        req = 8'hA0;
        step();
        req = 8'h00;
        step();
        check("pre_rst_valid", {31'd0, grant_valid}, 1);
        check("pre_rst_id", {29'd0, grant_id}, 7);
        check("pre_rst_pend", {24'd0, pending}, 8'hA0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, grant_valid}, 0);
        check("async_rst_id", {29'd0, grant_id}, 0);
        check("async_rst_pend", {24'd0, pending}, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", {31'd0, grant_valid}, 0);

        // single request with a long-held grant
        req = 8'h04;
        step();
        req = 8'h00;
        check("single_pend", {24'd0, pending}, 8'h04);
        check("single_latency", {31'd0, grant_valid}, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("single_hold_valid", {31'd0, grant_valid}, 1);
            check("single_hold_id", {29'd0, grant_id}, 2);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("single_ack_valid", {31'd0, grant_valid}, 0);
        check("single_ack_pend", {24'd0, pending}, 0);
        step();
        check("single_stay_idle", {31'd0, grant_valid}, 0);

        // priority drain with ack tied high
        req = 8'h91;
        ack = 1'b1;
        step();
        req = 8'h00;
        check("drain_pend0", {24'd0, pending}, 8'h91);
        step();
        check("drain_g7", {28'd0, grant_valid, grant_id}, {1'b1, 3'd7});
        step();
        check("drain_gap1", {31'd0, grant_valid}, 0);
        check("drain_pend1", {24'd0, pending}, 8'h11);
        step();
        check("drain_g4", {28'd0, grant_valid, grant_id}, {1'b1, 3'd4});
        step();
        check("drain_gap2", {31'd0, grant_valid}, 0);
        step();
        check("drain_g0", {28'd0, grant_valid, grant_id}, {1'b1, 3'd0});
        step();
        check("drain_end_valid", {31'd0, grant_valid}, 0);
        check("drain_end_pend", {24'd0, pending}, 0);
        ack = 1'b0;
        step();

        // no preemption by a higher-priority arrival
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        check("nopre_g1", {28'd0, grant_valid, grant_id}, {1'b1, 3'd1});
        req = 8'h40;
        step();
        req = 8'h00;
        check("nopre_hold_id", {29'd0, grant_id}, 1);
        check("nopre_pend", {24'd0, pending}, 8'h42);
        step();
        check("nopre_hold_id2", {29'd0, grant_id}, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("nopre_ack_valid", {31'd0, grant_valid}, 0);
        check("nopre_ack_pend", {24'd0, pending}, 8'h40);
        step();
        check("nopre_next_g6", {28'd0, grant_valid, grant_id}, {1'b1, 3'd6});
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("nopre_done_pend", {24'd0, pending}, 0);

        // set beats clear: held request re-pends across its own ack
        req = 8'h08;
        step();
        check("sbc_pend", {24'd0, pending}, 8'h08);
        step();
        check("sbc_g3", {28'd0, grant_valid, grant_id}, {1'b1, 3'd3});
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sbc_gap_valid", {31'd0, grant_valid}, 0);
        check("sbc_still_pend", {24'd0, pending}, 8'h08);
        step();
        check("sbc_regrant", {28'd0, grant_valid, grant_id}, {1'b1, 3'd3});
        req = 8'h00;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sbc_clear_pend", {24'd0, pending}, 0);
        check("sbc_clear_valid", {31'd0, grant_valid}, 0);
        step();

        // exhaustive: first grant is the highest set bit
        for (int p = 0; p < 256; p++) begin
            req = 8'(p);
            step();
            req = 8'h00;
            step();
            hi = -1;
            for (int b = 0; b < 8; b++) if (p[b]) hi = b;
            if (p == 0) check("exh_zero_valid", {31'd0, grant_valid}, 0);
            else check($sformatf("exh_%02h", p), {28'd0, grant_valid, grant_id}, {1'b1, 3'(hi)});
            ack = 1'b1;
            done = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                step();
                done = (pending == 8'h00) && !grant_valid;
            end
            ack = 1'b0;
            if (!done) check($sformatf("exh_drain_timeout_%02h", p), 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
